// File: rtl/duck_ctl.sv
// duck_ctl: per-frame fly/hit/fall/escape sequencing for one duck sprite.
// Define DUCK_CTL_ANIM_EN to enable the wing-flap anim_frame toggle in FLY/ESCAPE.
module duck_ctl #(
   parameter int WIDTH         = 48,
   parameter int X_MIN         = 0,
   parameter int X_MAX         = 800 - WIDTH,
   parameter int Y_MIN         = 0,
   parameter int Y_MAX         = 400,
   parameter int SPEED_X       = 2,
   parameter int SPEED_Y       = 2,
   parameter int FALL_SPEED    = 4,
   parameter int HIT_FRAMES    = 30,
   parameter int ESCAPE_FRAMES = 600,
   parameter int ANIM_DIV      = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start,
   input  logic [10:0] start_x,
   input  logic        start_left,
   input  logic        hit,
   output logic [10:0] xpos,
   output logic [10:0] ypos,
   output logic        invert,
   output logic [1:0]  anim_frame,
   output logic [2:0]  state,
   output logic        busy,
   output logic        escaped,
   output logic        fallen
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FLY  = 3'd1,
      S_HIT  = 3'd2,
      S_FALL = 3'd3,
      S_ESC  = 3'd4
   } state_e;

   localparam int CNT_MAX = (ESCAPE_FRAMES > HIT_FRAMES) ? ESCAPE_FRAMES : HIT_FRAMES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [11:0] XMIN12 = 12'(X_MIN);
   localparam logic [11:0] XMAX12 = 12'(X_MAX);
   localparam logic [11:0] YMIN12 = 12'(Y_MIN);
   localparam logic [11:0] YMAX12 = 12'(Y_MAX);
   localparam logic [11:0] SPX12  = 12'(SPEED_X);
   localparam logic [11:0] SPY12  = 12'(SPEED_Y);
   localparam logic [11:0] FALL12 = 12'(FALL_SPEED);
   localparam logic [CW-1:0] ESC_N = CW'(ESCAPE_FRAMES);
   localparam logic [CW-1:0] HIT_N = CW'(HIT_FRAMES);

   state_e      state_q;
   logic [10:0] xpos_q, ypos_q;
   logic        inv_q, ydn_q, hit_q, esc_q, fal_q;
   logic [1:0]  anim_q;
   logic [CW-1:0] cnt_q, cnt_inc;

   // 12-bit working values so steps past either bound never wrap.
   logic [11:0] x_ext, y_ext, sx_ext, x_add, x_sub, y_add, y_sub, y_fall;
   logic [10:0] x_fly_d, y_fly_d, sx_clamp_d;
   logic        inv_fly_d, ydn_fly_d, hit_any, aph_d;

   assign x_ext   = {1'b0, xpos_q};
   assign y_ext   = {1'b0, ypos_q};
   assign sx_ext  = {1'b0, start_x};
   assign x_add   = x_ext + SPX12;
   assign x_sub   = x_ext - SPX12;
   assign y_add   = y_ext + SPY12;
   assign y_sub   = y_ext - SPY12;
   assign y_fall  = y_ext + FALL12;
   assign cnt_inc = cnt_q + CW'(1);
   assign hit_any = hit_q | hit;

   always_comb begin
      x_fly_d   = xpos_q;
      inv_fly_d = inv_q;
      if (!inv_q) begin
         if (x_add > XMAX12) begin
            x_fly_d   = 11'(X_MAX);
            inv_fly_d = 1'b1;
         end else begin
            x_fly_d = 11'(x_add);
         end
      end else if (x_ext < XMIN12 + SPX12) begin
         x_fly_d   = 11'(X_MIN);
         inv_fly_d = 1'b0;
      end else begin
         x_fly_d = 11'(x_sub);
      end
   end

   always_comb begin
      y_fly_d   = ypos_q;
      ydn_fly_d = ydn_q;
      if (!ydn_q) begin
         if (y_ext < YMIN12 + SPY12) begin
            y_fly_d   = 11'(Y_MIN);
            ydn_fly_d = 1'b1;
         end else begin
            y_fly_d = 11'(y_sub);
         end
      end else if (y_add > YMAX12) begin
         y_fly_d   = 11'(Y_MAX);
         ydn_fly_d = 1'b0;
      end else begin
         y_fly_d = 11'(y_add);
      end
   end

   always_comb begin
      sx_clamp_d = start_x;
      if (sx_ext <= XMIN12)      sx_clamp_d = 11'(X_MIN);
      else if (sx_ext >= XMAX12) sx_clamp_d = 11'(X_MAX);
   end

`ifdef DUCK_CTL_ANIM_EN
   localparam int AW = $clog2(ANIM_DIV + 1);
   logic [AW-1:0] acnt_q, acnt_d;
   logic          aph_q;

   always_comb begin
      acnt_d = acnt_q + AW'(1);
      aph_d  = aph_q;
      if (acnt_q == AW'(ANIM_DIV - 1)) begin
         acnt_d = '0;
         aph_d  = ~aph_q;
      end
   end

   // Held at zero in IDLE, so every launch restarts the flap phase.
   always_ff @(posedge pclk) begin
      if (rst || state_q == S_IDLE) begin
         acnt_q <= '0;
         aph_q  <= 1'b0;
      end else if (frame_tick && ((state_q == S_FLY && !hit_any) || state_q == S_ESC)) begin
         acnt_q <= acnt_d;
         aph_q  <= aph_d;
      end
   end
`else
   assign aph_d = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= S_IDLE;
         xpos_q  <= '0;
         ypos_q  <= 11'(Y_MAX);
         inv_q   <= 1'b0;
         ydn_q   <= 1'b0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
         anim_q  <= 2'd0;
         esc_q   <= 1'b0;
         fal_q   <= 1'b0;
      end else begin
         esc_q <= 1'b0;
         fal_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               xpos_q  <= sx_clamp_d;
               ypos_q  <= 11'(Y_MAX);
               inv_q   <= start_left;
               ydn_q   <= 1'b0;
               hit_q   <= 1'b0;
               cnt_q   <= '0;
               anim_q  <= 2'd0;
               state_q <= S_FLY;
            end
            S_FLY: if (frame_tick) begin
               hit_q <= 1'b0;
               if (hit_any) begin
                  // a pending hit wins over escape expiry on the same tick
                  state_q <= S_HIT;
                  cnt_q   <= '0;
                  anim_q  <= 2'd2;
               end else begin
                  xpos_q <= x_fly_d;
                  inv_q  <= inv_fly_d;
                  ypos_q <= y_fly_d;
                  ydn_q  <= ydn_fly_d;
                  cnt_q  <= cnt_inc;
                  anim_q <= {1'b0, aph_d};
                  if (cnt_inc == ESC_N) state_q <= S_ESC;
               end
            end else if (hit) begin
               hit_q <= 1'b1;
            end
            S_HIT: if (frame_tick) begin
               cnt_q <= cnt_inc;
               if (cnt_inc == HIT_N) begin
                  state_q <= S_FALL;
                  anim_q  <= 2'd3;
               end
            end
            S_FALL: if (frame_tick) begin
               if (y_fall >= YMAX12) begin
                  ypos_q  <= 11'(Y_MAX);
                  fal_q   <= 1'b1;
                  anim_q  <= 2'd0;
                  state_q <= S_IDLE;
               end else begin
                  ypos_q <= 11'(y_fall);
               end
            end
            S_ESC: if (frame_tick) begin
               xpos_q <= x_fly_d;
               inv_q  <= inv_fly_d;
               if (y_ext < SPY12) begin
                  ypos_q  <= '0;
                  esc_q   <= 1'b1;
                  anim_q  <= 2'd0;
                  state_q <= S_IDLE;
               end else begin
                  ypos_q <= 11'(y_sub);
                  anim_q <= {1'b0, aph_d};
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign invert     = inv_q;
   assign anim_frame = anim_q;
   assign state      = state_q;
   assign busy       = (state_q != S_IDLE);
   assign escaped    = esc_q;
   assign fallen     = fal_q;

endmodule

// File: tb/tb_duck_ctl.sv
// tb_duck_ctl: directed stimulus on two duck_ctl instances (default and
// ESCAPE_FRAMES=4) checked every cycle against a behavioural model.
module tb_duck_ctl;
   logic        pclk = 1'b0, rst = 1'b1, frame_tick = 1'b0, start = 1'b0;
   logic        start_left = 1'b0, hit = 1'b0;
   logic [10:0] start_x = '0;

   logic [10:0] a_x, a_y, b_x, b_y;
   logic        a_inv, b_inv, a_busy, b_busy, a_esc, b_esc, a_fal, b_fal;
   logic [1:0]  a_an, b_an;
   logic [2:0]  a_st, b_st;

   int checks = 0, errors = 0, ncyc = 0, nfal_a = 0, nesc_b = 0;

`ifdef DUCK_CTL_ANIM_EN
   localparam bit ANIM = 1'b1;
`else
   localparam bit ANIM = 1'b0;
`endif

   duck_ctl u_a (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .start_x(start_x), .start_left(start_left), .hit(hit),
      .xpos(a_x), .ypos(a_y), .invert(a_inv), .anim_frame(a_an),
      .state(a_st), .busy(a_busy), .escaped(a_esc), .fallen(a_fal));

   duck_ctl #(.ESCAPE_FRAMES(4)) u_b (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .start_x(start_x), .start_left(start_left), .hit(hit),
      .xpos(b_x), .ypos(b_y), .invert(b_inv), .anim_frame(b_an),
      .state(b_st), .busy(b_busy), .escaped(b_esc), .fallen(b_fal));

   always #5 pclk = ~pclk;

   // Model: positions as signed ints, tick counters, a pending-hit flag.
   typedef struct {
      int st, x, y, fr, t;
      bit inv, down, hl, esc, fal;
   } mdl_t;

   function automatic mdl_t m_reset();
      mdl_t m;
      m.st = 0; m.x = 0; m.y = 400; m.fr = 0; m.t = 0;
      m.inv = 0; m.down = 0; m.hl = 0; m.esc = 0; m.fal = 0;
      return m;
   endfunction

   function automatic mdl_t m_xmove(mdl_t m);
      int v;
      v = m.inv ? m.x - 2 : m.x + 2;
      if (v > 752) begin v = 752; m.inv = 1; end
      else if (v < 0) begin v = 0; m.inv = 0; end
      m.x = v;
      return m;
   endfunction

   function automatic mdl_t m_step(mdl_t m, bit r, bit tk, bit st, int sx, bit sl,
                                   bit h, int escf);
      mdl_t n;
      int v;
      if (r) return m_reset();
      n = m; n.esc = 0; n.fal = 0;
      case (m.st)
         0: if (st) begin
            n.st = 1; n.x = (sx > 752) ? 752 : sx; n.y = 400; n.inv = sl;
            n.down = 0; n.fr = 0; n.t = 0; n.hl = 0;
         end
         1: if (tk) begin
            if (m.hl || h) begin n.st = 2; n.fr = 0; n.hl = 0; end
            else begin
               n = m_xmove(n);
               v = m.down ? m.y + 2 : m.y - 2;
               if (v < 0) begin v = 0; n.down = 1; end
               else if (v > 400) begin v = 400; n.down = 0; end
               n.y = v; n.fr = m.fr + 1; n.t = m.t + 1;
               if (n.fr == escf) n.st = 4;
            end
         end else if (h) n.hl = 1;
         2: if (tk) begin n.fr = m.fr + 1; if (n.fr == 30) n.st = 3; end
         3: if (tk) begin
            n.y = m.y + 4;
            if (n.y >= 400) begin n.y = 400; n.fal = 1; n.st = 0; end
         end
         4: if (tk) begin
            n = m_xmove(n); n.t = m.t + 1;
            if (m.y < 2) begin n.y = 0; n.esc = 1; n.st = 0; end
            else n.y = m.y - 2;
         end
         default: n.st = 0;
      endcase
      return n;
   endfunction

   function automatic int m_anim(mdl_t m);
      case (m.st)
         0: return 0;
         2: return 2;
         3: return 3;
         default: return ANIM ? (m.t / 8) % 2 : 0;
      endcase
   endfunction

   mdl_t ma, mb;
   always @(posedge pclk) begin
      ma <= m_step(ma, rst, frame_tick, start, int'(start_x), start_left, hit, 600);
      mb <= m_step(mb, rst, frame_tick, start, int'(start_x), start_left, hit, 4);
   end

   task automatic cmp(input string nm, input mdl_t m, input logic [2:0] st,
                      input logic [10:0] x, input logic [10:0] y, input logic inv,
                      input logic [1:0] an, input logic bz, input logic es, input logic fl);
      logic [30:0] act, exp;
      act = {st, x, y, inv, an, bz, es, fl};
      exp = {3'(m.st), 11'(m.x), 11'(m.y), m.inv, 2'(m_anim(m)), (m.st != 0), m.esc, m.fal};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d actual st=%0d x=%0d y=%0d inv=%0d anim=%0d busy=%0d esc=%0d fal=%0d required st=%0d x=%0d y=%0d inv=%0d anim=%0d busy=%0d esc=%0d fal=%0d",
                  nm, ncyc, st, x, y, inv, an, bz, es, fl,
                  m.st, m.x, m.y, m.inv, m_anim(m), (m.st != 0), m.esc, m.fal);
      end
   endtask

   always @(negedge pclk) begin
      ncyc++;
      cmp("model_a", ma, a_st, a_x, a_y, a_inv, a_an, a_busy, a_esc, a_fal);
      cmp("model_b", mb, b_st, b_x, b_y, b_inv, b_an, b_busy, b_esc, b_fal);
      if (a_fal === 1'b1) nfal_a++;
      if (b_esc === 1'b1) nesc_b++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic tick();
      @(negedge pclk); frame_tick = 1'b1;
      @(negedge pclk); frame_tick = 1'b0;
      @(negedge pclk);
   endtask

   task automatic do_start(input int sx, input bit sl, input bit with_tick);
      @(negedge pclk); start = 1'b1; start_x = 11'(sx); start_left = sl; frame_tick = with_tick;
      @(negedge pclk); start = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic do_hit();
      @(negedge pclk); hit = 1'b1;
      @(negedge pclk); hit = 1'b0;
   endtask

   task automatic do_rst();
      @(negedge pclk); rst = 1'b1;
      @(negedge pclk); rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", ncyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nt;
      idle(3); rst = 1'b0;
      chk("rst_state", a_st, 0);   chk("rst_x", a_x, 0);     chk("rst_y", a_y, 400);
      chk("rst_inv", a_inv, 0);    chk("rst_anim", a_an, 0); chk("rst_busy", a_busy, 0);
      chk("rst_esc", a_esc, 0);    chk("rst_fal", a_fal, 0);

      // launch and fly
      do_start(100, 0, 0);
      chk("start_state", a_st, 1); chk("start_x", a_x, 100); chk("start_y", a_y, 400);
      chk("start_inv", a_inv, 0);  chk("start_busy", a_busy, 1);
      repeat (3) tick();
      chk("fly3_x", a_x, 106); chk("fly3_y", a_y, 394);

      // hit mid-frame, taken at the next tick; B's 4th tick would have expired
      do_hit(); idle(2);
      chk("hit_pending_state", a_st, 1);
      tick();
      chk("hit_state", a_st, 2); chk("hit_x", a_x, 106); chk("hit_y", a_y, 394);
      chk("hit_beats_escape", b_st, 2);
      do_start(300, 1, 0); do_hit();
      repeat (29) tick();
      chk("hit29_state", a_st, 2); chk("hit29_x", a_x, 106);
      tick();
      chk("fall_state", a_st, 3); chk("fall_y0", a_y, 394);
      tick();
      chk("fall_y1", a_y, 398); chk("fall1_state", a_st, 3);
      tick();
      chk("land_y", a_y, 400); chk("land_state", a_st, 0); chk("fallen_pulses", nfal_a, 1);

      // start on a tick cycle, right-bound bounce, then B escapes
      do_start(751, 0, 1);
      chk("start_tick_x", a_x, 751); chk("start_tick_state", a_st, 1);
      tick();
      chk("bounce_x", a_x, 752); chk("bounce_inv", a_inv, 1); chk("bounce_y", a_y, 398);
      tick();
      chk("bounce2_x", a_x, 750); chk("bounce2_inv", a_inv, 1);
      repeat (2) tick();
      nt = 4;
      chk("esc_state", b_st, 4); chk("esc_y", b_y, 392); chk("a_still_fly", a_st, 1);
      k = 0;
      while (b_st != 3'd0 && k < 300) begin
         tick(); k++; nt++;
         if (nt == 7)  chk("anim_t7", a_an, 0);
         if (nt == 8)  chk("anim_t8", a_an, ANIM ? 1 : 0);
         if (nt == 15) chk("anim_t15", a_an, ANIM ? 1 : 0);
         if (nt == 16) chk("anim_t16", a_an, 0);
      end
      chk("esc_ticks", k, 197); chk("esc_final_y", b_y, 0); chk("escaped_pulses", nesc_b, 1);

      // start_x clamp
      do_rst();
      chk("rst2_state", a_st, 0); chk("rst2_y", a_y, 400);
      do_start(2000, 1, 0);
      chk("clamp_x", a_x, 752); chk("clamp_inv", a_inv, 1);
      tick();
      chk("clamp_step_x", a_x, 750);

      // left bound, hit on B's expiry tick, reset during FALL
      do_rst();
      do_start(1, 1, 0);
      tick();
      chk("left_x", a_x, 0); chk("left_inv", a_inv, 0);
      tick();
      chk("left2_x", a_x, 2);
      tick();
      chk("left3_x", a_x, 4); chk("left3_y", a_y, 394);
      do_hit(); tick();
      chk("hit4_b_state", b_st, 2); chk("hit4_a_state", a_st, 2);
      repeat (30) tick();
      chk("fall2_state", a_st, 3);
      tick();
      chk("fall2_y", a_y, 398);
      do_rst();
      chk("rstfall_state", a_st, 0); chk("rstfall_x", a_x, 0); chk("rstfall_y", a_y, 400);
      chk("rstfall_inv", a_inv, 0);  chk("rstfall_anim", a_an, 0); chk("rstfall_busy", a_busy, 0);
      chk("rstfall_fal", a_fal, 0);

      // pending hit discarded by reset
      do_start(200, 0, 0); do_hit(); do_rst(); tick();
      chk("rsthit_state", a_st, 0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/duck_ctl.md
# duck_ctl

Per-frame motion and life-cycle controller for one duck sprite. It sequences the `xpos`, `ypos` and `invert` inputs of the sprite drawing stage, plus an animation frame index for the sprite ROM address upper bits. It advances once per video frame and drives fly, hit, fall and escape behaviour in response to `start` and `hit` from game logic. It sits between the game FSM and the sprite renderer in the video pipeline.

## Interface
- `WIDTH`, 48: sprite width in pixels.
- `X_MIN`, 0: left bound for `xpos`.
- `X_MAX`, 752: right bound for `xpos` (800 minus `WIDTH`).
- `Y_MIN`, 0: top bound for `ypos`.
- `Y_MAX`, 400: ground line; spawn and landing `ypos`.
- `SPEED_X`, 2: horizontal pixels per frame while flying.
- `SPEED_Y`, 2: vertical pixels per frame while flying.
- `FALL_SPEED`, 4: downward pixels per frame while falling.
- `HIT_FRAMES`, 30: frames held in HIT.
- `ESCAPE_FRAMES`, 600: frames spent in FLY before ESCAPE.
- `ANIM_DIV`, 8: frames per wing-flap toggle.
- `pclk`, input, 1: pixel clock. Sole clock.
- `rst`, input, 1: synchronous, active-high reset.
- `frame_tick`, input, 1: single-cycle pulse, once per frame, at vblank start.
- `start`, input, 1: single-cycle launch request.
- `start_x`, input, 11: spawn x position.
- `start_left`, input, 1: initial horizontal direction (1 = left).
- `hit`, input, 1: single-cycle shot-hit pulse; may arrive on any cycle.
- `xpos`, output, 11: sprite x position. Registered.
- `ypos`, output, 11: sprite y position. Registered.
- `invert`, output, 1: 1 while heading left. Registered.
- `anim_frame`, output, 2: sprite frame select. Registered.
- `state`, output, 3: IDLE=0, FLY=1, HIT=2, FALL=3, ESCAPE=4.
- `busy`, output, 1: high when `state` is not IDLE.
- `escaped`, output, 1: one-cycle pulse when the duck leaves the top of the screen.
- `fallen`, output, 1: one-cycle pulse when the duck lands.

## Operation
- Reset values: `state` IDLE, `xpos` 0, `ypos` `Y_MAX`, `invert` 0, `anim_frame` 0, `escaped` 0, `fallen` 0. Internal hit latch, frame counter and anim counter cleared.
- IDLE:
  - `start` (any cycle) loads `xpos` from `start_x` clamped to [`X_MIN`, `X_MAX`], `ypos` from `Y_MAX`, and `invert` from `start_left`.
  - Vertical direction is set to up; frame counter cleared; next state FLY.
  - `start` in any other state is ignored.
- FLY, on each `frame_tick`:
  - x moves `SPEED_X` in the current direction. If the step would cross a bound, x clamps to that bound and the direction flips (`invert` toggles) in the same update.
  - y moves the same way between `Y_MIN` and `Y_MAX`, flipping its own direction at a bound.
  - Frame counter increments. On reaching `ESCAPE_FRAMES`, next state is ESCAPE.
- Hit latch:
  - Set by `hit` only while in FLY; held until the next `frame_tick`.
  - At that tick: state goes to HIT, the position is not updated, and the frame counter clears.
  - Latched hit beats escape expiry on the same tick.
  - Latch clears on leaving FLY; `hit` outside FLY is ignored.
- HIT: position frozen; after `HIT_FRAMES` ticks, next state FALL.
- FALL, per tick: `ypos` += `FALL_SPEED`. If the result is >= `Y_MAX`, `ypos` = `Y_MAX`, `fallen` pulses, and the next state is IDLE.
- ESCAPE, per tick: x keeps its FLY motion and `ypos` -= `SPEED_Y`. If `ypos` < `SPEED_Y` before the step, `ypos` = 0, `escaped` pulses, and the next state is IDLE.
- Arithmetic: 12-bit intermediates for all bound checks, so underflow and overflow never wrap. Outputs are always within their bounds.
- `anim_frame`: 0 in IDLE, 2 in HIT, 3 in FALL; FLY and ESCAPE per Configuration.

## Timing
- All outputs are registered.
- A state or position change takes effect on the cycle after the `frame_tick` (or `start`) that caused it; latency 1.
- `escaped` and `fallen` are high for exactly the cycle on which `state` becomes IDLE.
- Between ticks, outputs hold, so they are stable for the whole active video region.
- `start` and `frame_tick` on the same cycle in IDLE: `start` is taken, with no motion that tick.
- `rst` mid-operation returns all outputs to reset values on the next edge, regardless of pending hit.

## Configuration
- `DUCK_CTL_ANIM_EN` defined:
  - In FLY and ESCAPE, `anim_frame` toggles between 0 and 1 every `ANIM_DIV` ticks.
  - The anim counter restarts at 0 on entry to FLY.
- Not defined:
  - `anim_frame` is constant 0 in FLY and ESCAPE; no anim counter is synthesised.
  - HIT and FALL values are unchanged.

## Test plan
- Reset, then `start` with `start_x`=100, `start_left`=0 -> next cycle `state`=1, `xpos`=100, `ypos`=400, `invert`=0; after 3 ticks `xpos`=106, `ypos`=394.
- `start_x`=751, moving right -> next tick `xpos`=752, `invert`=1; the tick after, `xpos`=750.
- `hit` mid-frame in FLY -> following tick `state`=2 with position unchanged; 30 ticks later `state`=3; `ypos` climbs by 4 per tick to 400, then `fallen` pulses once and `state`=0.
- `ESCAPE_FRAMES`=4 and `hit` latched before the 4th tick -> `state`=2, not 4. Without the hit -> `state`=4, `ypos` falls to 0, `escaped` pulses once.
- `rst` asserted in FALL -> next cycle all outputs at reset values; `hit` and `start` issued in HIT -> ignored.
- With `DUCK_CTL_ANIM_EN` and `ANIM_DIV`=8 -> `anim_frame` is 0 for ticks 0-7 and 1 for ticks 8-15. Without the macro -> always 0 in FLY.
